// File: rtl/pipeline_wb.sv
// pipeline_wb: write-back stage; ALU results retire directly, loads fetch a word and extend it.
// Define WB_RETIRE_CNT_EN to add the retire_cnt output counting register-file writes.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef REG_NUM
`define REG_NUM 5
`endif

module pipeline_wb (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [`REG_NUM-1:0]      in_rd,
    input  logic [`COMMON_WIDTH-1:0] in_result,
    input  logic                     in_write_alu_result_tag,
    input  logic                     in_load_tag,
    input  logic [2:0]               in_load_type,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic [`COMMON_WIDTH-1:0] mem_addr,
    input  logic                     mem_resp_valid,
    input  logic [`COMMON_WIDTH-1:0] mem_resp_data,
    output logic [`REG_NUM-1:0]      reg_write,
    output logic [`COMMON_WIDTH-1:0] data_write,
    output logic                     misalign_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]              retire_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t                 state;
    logic [`REG_NUM-1:0]    rd_q;
    logic [2:0]             type_q;
    logic [1:0]             off_q;
    logic                   is_half, is_byte, load_mis;
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [`COMMON_WIDTH-1:0] ext;
    assign in_ready = state == S_IDLE;
    assign is_half  = in_load_type == 3'd1 || in_load_type == 3'd5;
    assign is_byte  = in_load_type == 3'd0 || in_load_type == 3'd4;
    assign load_mis = is_half ? in_result[0] : is_byte ? 1'b0 : |in_result[1:0];
    assign byte_sel = 8'(mem_resp_data >> {off_q, 3'b000});
    assign half_sel = off_q[1] ? mem_resp_data[31:16] : mem_resp_data[15:0];
    // Unlisted load types fall through to a whole-word load.
    assign ext = type_q == 3'd0 ? {{24{byte_sel[7]}}, byte_sel} :
                 type_q == 3'd4 ? {24'b0, byte_sel} :
                 type_q == 3'd1 ? {{16{half_sel[15]}}, half_sel} :
                 type_q == 3'd5 ? {16'b0, half_sel} : mem_resp_data;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            rd_q          <= '0;
            type_q        <= '0;
            off_q         <= '0;
            mem_addr      <= '0;
            mem_req_valid <= 1'b0;
            reg_write     <= '0;
            data_write    <= '0;
            misalign_err  <= 1'b0;
        end else begin
            reg_write    <= '0;
            misalign_err <= 1'b0;
            case (state)
                S_IDLE: if (in_valid) begin
                    if (in_load_tag) begin
                        rd_q   <= in_rd;
                        type_q <= in_load_type;
                        off_q  <= in_result[1:0];
                        if (load_mis) misalign_err <= 1'b1;
                        else begin
                            mem_addr      <= {in_result[`COMMON_WIDTH-1:2], 2'b00};
                            mem_req_valid <= 1'b1;
                            state         <= S_REQ;
                        end
                    end else if (in_write_alu_result_tag) begin
                        reg_write  <= in_rd;
                        data_write <= in_result;
                    end
                end
                S_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    state         <= S_WAIT;
                end
                S_WAIT: if (mem_resp_valid) begin
                    reg_write  <= rd_q;
                    data_write <= ext;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) retire_cnt <= '0;
        else if (reg_write != '0) retire_cnt <= retire_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_pipeline_wb.sv
// tb_pipeline_wb: table-driven vectors plus hand sequences, write-back scoreboard.
module tb_pipeline_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_result = '0;
    logic        in_write_alu_result_tag = 1'b0, in_load_tag = 1'b0;
    logic [2:0]  in_load_type = '0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic [4:0]  reg_write;
    logic [31:0] data_write;
    logic        misalign_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif
    pipeline_wb dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_result(in_result), .in_write_alu_result_tag(in_write_alu_result_tag),
        .in_load_tag(in_load_tag), .in_load_type(in_load_type),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .reg_write(reg_write), .data_write(data_write), .misalign_err(misalign_err)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic        tag;
        logic [2:0]  ltype;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] resp;
        int          stall;
        int          dly;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[15];
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;
    int          checks = 0, failures = 0, n_pushed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back({rd, d});
        n_pushed++;
    endtask

    always @(negedge clk) begin
        if (rst && reg_write != 5'd0) begin
            if (exp_q.size() == 0) chk("unexpected_write", {27'b0, reg_write}, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", {27'b0, reg_write}, {27'b0, mon_e[36:32]});
                chk("wb_data", data_write, mon_e[31:0]);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic [31:0] a;
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_rd = v.rd; in_result = v.addr;
        in_write_alu_result_tag = v.tag; in_load_tag = v.load; in_load_type = v.ltype;
        if (v.exp_rd != 5'd0) expect_wr(v.exp_rd, v.exp_data);
        step();
        in_valid = 1'b0; in_load_tag = 1'b0; in_write_alu_result_tag = 1'b0;
        chk("misalign", {31'b0, misalign_err}, {31'b0, v.exp_mis});
        if (v.load && !v.exp_mis) begin
            a = v.addr & 32'hFFFF_FFFC;
            chk("req_valid", {31'b0, mem_req_valid}, 32'd1);
            chk("mem_addr", mem_addr, a);
            for (int i = 0; i < v.stall; i++) begin
                step();
                chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
                chk("stall_addr", mem_addr, a);
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            end
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
            chk("req_drop", {31'b0, mem_req_valid}, 32'd0);
            for (int i = 0; i < v.dly; i++) begin
                chk("wait_in_ready", {31'b0, in_ready}, 32'd0);
                step();
            end
            mem_resp_valid = 1'b1; mem_resp_data = v.resp;
            step();
            mem_resp_valid = 1'b0;
            chk("in_ready_after", {31'b0, in_ready}, 32'd1);
        end else chk("no_req", {31'b0, mem_req_valid}, 32'd0);
        step();
        chk("misalign_pulse", {31'b0, misalign_err}, 32'd0);
    endtask

    initial begin
        //         load  tag   type  rd     addr          resp          st dl exp_rd exp_data      mis
        vecs[0]  = '{1'b0, 1'b1, 3'd0, 5'd5,  32'h0000_1234, 32'h0,        0, 0, 5'd5,  32'h0000_1234, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 3'd0, 5'd0,  32'h0000_FFFF, 32'h0,        0, 0, 5'd0,  32'h0,         1'b0};
        vecs[2]  = '{1'b0, 1'b0, 3'd0, 5'd7,  32'h0000_0777, 32'h0,        0, 0, 5'd0,  32'h0,         1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 5'd3,  32'h0000_0103, 32'h80FF_FFFF, 2, 2, 5'd3,  32'hFFFF_FF80, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'd4, 5'd4,  32'h0000_0103, 32'h80FF_FFFF, 2, 2, 5'd4,  32'h0000_0080, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'd5, 5'd6,  32'h0000_0002, 32'hBEEF_1234, 0, 0, 5'd6,  32'h0000_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'd1, 5'd8,  32'h0000_0002, 32'hBEEF_1234, 1, 1, 5'd8,  32'hFFFF_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 5'd9,  32'h0000_0006, 32'h0,        0, 0, 5'd0,  32'h0,         1'b1};
        vecs[8]  = '{1'b1, 1'b0, 3'd1, 5'd9,  32'h0000_0001, 32'h0,        0, 0, 5'd0,  32'h0,         1'b1};
        vecs[9]  = '{1'b1, 1'b0, 3'd2, 5'd9,  32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 5'd9,  32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 3'd0, 5'd10, 32'h0000_0001, 32'h0000_7F00, 0, 1, 5'd10, 32'h0000_007F, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'd3, 5'd11, 32'h0000_0008, 32'h1234_5678, 0, 0, 5'd11, 32'h1234_5678, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'd3, 5'd11, 32'h0000_0009, 32'h0,        0, 0, 5'd0,  32'h0,         1'b1};
        vecs[13] = '{1'b1, 1'b0, 3'd2, 5'd0,  32'h0000_0000, 32'h5555_5555, 0, 0, 5'd0,  32'h0,         1'b0};
        vecs[14] = '{1'b1, 1'b1, 3'd0, 5'd12, 32'h0000_0002, 32'h00A5_0000, 1, 0, 5'd12, 32'hFFFF_FFA5, 1'b0};

        repeat (2) step();
        chk("rst_reg_write", {27'b0, reg_write}, 32'd0);
        chk("rst_data_write", data_write, 32'd0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // back-to-back ALU retirement
        in_valid = 1'b1; in_write_alu_result_tag = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_rd = 5'(i); in_result = 32'h100 + i;
            expect_wr(5'(i), 32'h100 + i);
            step();
            chk("b2b_rd", {27'b0, reg_write}, i);
            chk("b2b_ready", {31'b0, in_ready}, 32'd1);
        end
        in_valid = 1'b0; in_write_alu_result_tag = 1'b0;
        step();

        // response outside WAIT is ignored
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        repeat (2) begin step(); chk("idle_resp_ignored", {27'b0, reg_write}, 32'd0); end
        mem_resp_valid = 1'b0;

        // in_valid ignored in REQ/WAIT; ready and response together in WAIT
        in_valid = 1'b1; in_load_tag = 1'b1; in_load_type = 3'd2; in_rd = 5'd15; in_result = 32'h10;
        step();
        in_load_tag = 1'b0; in_write_alu_result_tag = 1'b1; in_rd = 5'd13; in_result = 32'h1313;
        step();
        chk("req_hold", {31'b0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
        expect_wr(5'd15, 32'hCAFE_F00D);
        step();
        in_valid = 1'b0; in_write_alu_result_tag = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        chk("both_rd", {27'b0, reg_write}, 32'd15);
        chk("both_req_valid", {31'b0, mem_req_valid}, 32'd0);
        repeat (2) step();

        // reset in REQ drops mem_req_valid on the same edge
        in_valid = 1'b1; in_load_tag = 1'b1; in_load_type = 3'd2; in_rd = 5'd14; in_result = 32'h20;
        step();
        in_valid = 1'b0; in_load_tag = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1; n_pushed = 0;
        chk("rst_req_drop", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, in_ready}, 32'd1);

        // reset in WAIT aborts the load; later response ignored
        in_valid = 1'b1; in_load_tag = 1'b1; in_load_type = 3'd2; in_rd = 5'd14; in_result = 32'h20;
        step();
        in_valid = 1'b0; in_load_tag = 1'b0; mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_wait_ready", {31'b0, in_ready}, 32'd1);
        mem_resp_valid = 1'b1; mem_resp_data = 32'h7777_7777;
        step();
        mem_resp_valid = 1'b0;
        chk("rst_wait_nowrite", {27'b0, reg_write}, 32'd0);
        step();
        chk("rst_wait_nowrite2", {27'b0, reg_write}, 32'd0);

        // post-reset writes for the retire counter
        in_valid = 1'b1; in_write_alu_result_tag = 1'b1;
        in_rd = 5'd21; in_result = 32'hA1; expect_wr(5'd21, 32'hA1); step();
        in_rd = 5'd0;  in_result = 32'hA2; step();
        in_rd = 5'd22; in_result = 32'hA3; expect_wr(5'd22, 32'hA3); step();
        in_valid = 1'b0; in_write_alu_result_tag = 1'b0;
        repeat (3) step();
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, n_pushed);
`endif
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
